// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite response codes, FSM state types and index-width helper.
package axi4_lite_pkg;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    typedef enum logic [1:0] {
        W_IDLE,
        W_PEND,
        W_RESP
    } wr_state_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rd_state_t;

    // Width of a register index; a single register still needs one bit.
    function automatic int idx_width(input int num_regs);
        return (num_regs > 1) ? $clog2(num_regs) : 1;
    endfunction

endpackage

// File: rtl/axi4_lite_regfile.sv
// AXI4-Lite slave register file with independent read and write paths.
module axi4_lite_regfile
    import axi4_lite_pkg::*;
#(
    parameter int ADDRESS    = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 32
) (
    input  logic                    ACLK,
    input  logic                    ARESETN,
    input  logic [ADDRESS-1:0]      S_AWADDR,
    input  logic                    S_AWVALID,
    output logic                    S_AWREADY,
    input  logic [DATA_WIDTH-1:0]   S_WDATA,
    input  logic [DATA_WIDTH/8-1:0] S_WSTRB,
    input  logic                    S_WVALID,
    output logic                    S_WREADY,
    output logic [1:0]              S_BRESP,
    output logic                    S_BVALID,
    input  logic                    S_BREADY,
    input  logic [ADDRESS-1:0]      S_ARADDR,
    input  logic                    S_ARVALID,
    output logic                    S_ARREADY,
    output logic [DATA_WIDTH-1:0]   S_RDATA,
    output logic [1:0]              S_RRESP,
    output logic                    S_RVALID,
    input  logic                    S_RREADY
);

    localparam int STRB_W   = DATA_WIDTH / 8;
    localparam int ADDR_LSB = $clog2(STRB_W);
    localparam int IDX_W    = idx_width(NUM_REGS);

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    wr_state_t             wr_state, wr_next;
    rd_state_t             rd_state, rd_next;

    logic                  aw_full, w_full;
    logic [IDX_W-1:0]      aw_idx_q;
    logic                  aw_ok_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [STRB_W-1:0]     wstrb_q;
    logic [1:0]            bresp_q, rresp_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    // Word addresses keep every upper bit so stray high bits decode as out of range.
    logic [ADDRESS-1:0]    aw_word, ar_word;
    logic                  aw_ok, ar_ok;
    logic [IDX_W-1:0]      aw_idx, ar_idx;
    logic                  aw_hs, w_hs, ar_hs;
    logic                  commit;
    logic [IDX_W-1:0]      c_idx;
    logic                  c_ok;
    logic [DATA_WIDTH-1:0] c_data;
    logic [STRB_W-1:0]     c_strb;

    assign aw_word = S_AWADDR >> ADDR_LSB;
    assign ar_word = S_ARADDR >> ADDR_LSB;
    assign aw_ok   = aw_word < ADDRESS'(NUM_REGS);
    assign ar_ok   = ar_word < ADDRESS'(NUM_REGS);
    assign aw_idx  = aw_word[IDX_W-1:0];
    assign ar_idx  = ar_word[IDX_W-1:0];

    assign S_BVALID  = (wr_state == W_RESP);
    assign S_RVALID  = (rd_state == R_DATA);
    assign S_BRESP   = bresp_q;
    assign S_RRESP   = rresp_q;
    assign S_RDATA   = rdata_q;
    // Readies are gated by reset so every output reads 0 while ARESETN is low.
    assign S_AWREADY = ARESETN && !aw_full && !S_BVALID;
    assign S_WREADY  = ARESETN && !w_full && !S_BVALID;
    assign S_ARREADY = ARESETN && !S_RVALID;

    assign aw_hs = S_AWVALID && S_AWREADY;
    assign w_hs  = S_WVALID && S_WREADY;
    assign ar_hs = S_ARVALID && S_ARREADY;

    // Commit as soon as both halves exist, whether held or arriving this cycle.
    assign commit = (aw_full || aw_hs) && (w_full || w_hs);
    assign c_idx  = aw_full ? aw_idx_q : aw_idx;
    assign c_ok   = aw_full ? aw_ok_q : aw_ok;
    assign c_data = w_full ? wdata_q : S_WDATA;
    assign c_strb = w_full ? wstrb_q : S_WSTRB;

    // Write FSM state register.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) wr_state <= W_IDLE;
        else          wr_state <= wr_next;
    end

    // Write FSM next state: a lone AW or W parks in W_PEND until its partner arrives.
    always_comb begin
        wr_next = wr_state;
        case (wr_state)
            W_IDLE:  if (commit) wr_next = W_RESP;
                     else if (aw_hs || w_hs) wr_next = W_PEND;
            W_PEND:  if (commit) wr_next = W_RESP;
            W_RESP:  if (S_BREADY) wr_next = W_IDLE;
            default: wr_next = W_IDLE;
        endcase
    end

    // Holding-register full flags and write response code.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            aw_full <= 1'b0;
            w_full  <= 1'b0;
            bresp_q <= OKAY;
        end else begin
            if (commit) begin
                aw_full <= 1'b0;
                w_full  <= 1'b0;
                bresp_q <= c_ok ? OKAY : DECERR;
            end else begin
                if (aw_hs) aw_full <= 1'b1;
                if (w_hs)  w_full  <= 1'b1;
            end
        end
    end

    // Holding-register payloads; only meaningful while the matching full flag is set.
    always_ff @(posedge ACLK) begin
        if (aw_hs) begin
            aw_idx_q <= aw_idx;
            aw_ok_q  <= aw_ok;
        end
        if (w_hs) begin
            wdata_q <= S_WDATA;
            wstrb_q <= S_WSTRB;
        end
    end

    // Register storage with per-byte-lane write enables.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (commit && c_ok) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (c_strb[b]) regs[c_idx][8*b +: 8] <= c_data[8*b +: 8];
            end
        end
    end

    // Read FSM state register.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) rd_state <= R_IDLE;
        else          rd_state <= rd_next;
    end

    // Read FSM next state.
    always_comb begin
        rd_next = rd_state;
        case (rd_state)
            R_IDLE:  if (ar_hs) rd_next = R_DATA;
            R_DATA:  if (S_RREADY) rd_next = R_IDLE;
            default: rd_next = R_IDLE;
        endcase
    end

    // Read data capture; sampled before a same-edge commit lands, and zeroed when idle.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            rdata_q <= '0;
            rresp_q <= OKAY;
        end else if (ar_hs) begin
            rdata_q <= ar_ok ? regs[ar_idx] : '0;
            rresp_q <= ar_ok ? OKAY : DECERR;
        end else if (S_RVALID && S_RREADY) begin
            rdata_q <= '0;
            rresp_q <= OKAY;
        end
    end

endmodule

// File: tb/tb_axi4_lite_regfile.sv
// Directed self-checking bench for axi4_lite_regfile (default parameters).
module tb_axi4_lite_regfile;

    logic        ACLK = 1'b0;
    logic        ARESETN;
    logic [31:0] S_AWADDR;
    logic        S_AWVALID;
    logic        S_AWREADY;
    logic [31:0] S_WDATA;
    logic [3:0]  S_WSTRB;
    logic        S_WVALID;
    logic        S_WREADY;
    logic [1:0]  S_BRESP;
    logic        S_BVALID;
    logic        S_BREADY;
    logic [31:0] S_ARADDR;
    logic        S_ARVALID;
    logic        S_ARREADY;
    logic [31:0] S_RDATA;
    logic [1:0]  S_RRESP;
    logic        S_RVALID;
    logic        S_RREADY;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    axi4_lite_regfile #(
        .ADDRESS    (32),
        .DATA_WIDTH (32),
        .NUM_REGS   (32)
    ) dut (
        .ACLK      (ACLK),
        .ARESETN   (ARESETN),
        .S_AWADDR  (S_AWADDR),
        .S_AWVALID (S_AWVALID),
        .S_AWREADY (S_AWREADY),
        .S_WDATA   (S_WDATA),
        .S_WSTRB   (S_WSTRB),
        .S_WVALID  (S_WVALID),
        .S_WREADY  (S_WREADY),
        .S_BRESP   (S_BRESP),
        .S_BVALID  (S_BVALID),
        .S_BREADY  (S_BREADY),
        .S_ARADDR  (S_ARADDR),
        .S_ARVALID (S_ARVALID),
        .S_ARREADY (S_ARREADY),
        .S_RDATA   (S_RDATA),
        .S_RRESP   (S_RRESP),
        .S_RVALID  (S_RVALID),
        .S_RREADY  (S_RREADY)
    );

    always #5 ACLK = ~ACLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic write_same(input string tag, input logic [31:0] addr,
                              input logic [31:0] data, input logic [3:0] strb,
                              input logic [1:0] resp);
        S_AWADDR = addr; S_AWVALID = 1'b1;
        S_WDATA = data; S_WSTRB = strb; S_WVALID = 1'b1;
        chk({tag, ".awready"}, S_AWREADY, 1);
        chk({tag, ".wready"}, S_WREADY, 1);
        tick();
        S_AWVALID = 1'b0; S_WVALID = 1'b0;
        chk({tag, ".bvalid"}, S_BVALID, 1);
        chk({tag, ".bresp"}, S_BRESP, resp);
        S_BREADY = 1'b1;
        tick();
        S_BREADY = 1'b0;
        chk({tag, ".bvalid_clr"}, S_BVALID, 0);
    endtask

    task automatic do_read(input string tag, input logic [31:0] addr,
                           input logic [31:0] data, input logic [1:0] resp);
        S_ARADDR = addr; S_ARVALID = 1'b1;
        chk({tag, ".arready"}, S_ARREADY, 1);
        tick();
        S_ARVALID = 1'b0;
        chk({tag, ".rvalid"}, S_RVALID, 1);
        chk({tag, ".rdata"}, S_RDATA, data);
        chk({tag, ".rresp"}, S_RRESP, resp);
        S_RREADY = 1'b1;
        tick();
        S_RREADY = 1'b0;
        chk({tag, ".rvalid_clr"}, S_RVALID, 0);
        chk({tag, ".rdata_idle"}, S_RDATA, 0);
    endtask

    initial begin
        ARESETN = 1'b0;
        S_AWADDR = '0; S_AWVALID = 1'b0;
        S_WDATA = '0; S_WSTRB = '0; S_WVALID = 1'b0;
        S_BREADY = 1'b0;
        S_ARADDR = '0; S_ARVALID = 1'b0;
        S_RREADY = 1'b0;

        // Outputs held at zero during reset
        tick();
        tick();
        chk("rst.awready", S_AWREADY, 0);
        chk("rst.wready", S_WREADY, 0);
        chk("rst.arready", S_ARREADY, 0);
        chk("rst.bvalid", S_BVALID, 0);
        chk("rst.rvalid", S_RVALID, 0);
        chk("rst.rdata", S_RDATA, 0);
        ARESETN = 1'b1;
        #1;
        chk("post_rst.awready", S_AWREADY, 1);
        chk("post_rst.wready", S_WREADY, 1);
        chk("post_rst.arready", S_ARREADY, 1);

        // AW and W together, then read back
        write_same("wr08", 32'h08, 32'hDEADBEEF, 4'hF, 2'b00);
        do_read("rd08", 32'h08, 32'hDEADBEEF, 2'b00);

        // W three cycles ahead of AW
        S_WDATA = 32'h11223344; S_WSTRB = 4'hF; S_WVALID = 1'b1;
        tick();
        S_WVALID = 1'b0;
        chk("wfirst.wready", S_WREADY, 0);
        chk("wfirst.awready", S_AWREADY, 1);
        chk("wfirst.bvalid", S_BVALID, 0);
        tick();
        tick();
        chk("wfirst.wready_hold", S_WREADY, 0);
        chk("wfirst.awready_hold", S_AWREADY, 1);
        chk("wfirst.bvalid_hold", S_BVALID, 0);
        S_AWADDR = 32'h0C; S_AWVALID = 1'b1;
        tick();
        S_AWVALID = 1'b0;
        chk("wfirst.bvalid", S_BVALID, 1);
        chk("wfirst.bresp", S_BRESP, 2'b00);
        chk("wfirst.awready_resp", S_AWREADY, 0);
        S_BREADY = 1'b1;
        tick();
        S_BREADY = 1'b0;
        chk("wfirst.bvalid_clr", S_BVALID, 0);
        do_read("rd0c", 32'h0C, 32'h11223344, 2'b00);

        // Byte strobes
        write_same("wr10", 32'h10, 32'hAABBCCDD, 4'hF, 2'b00);
        write_same("wr10_b0", 32'h10, 32'h00000055, 4'h1, 2'b00);
        do_read("rd10_b0", 32'h10, 32'hAABBCC55, 2'b00);
        write_same("wr10_none", 32'h10, 32'hFFFFFFFF, 4'h0, 2'b00);
        do_read("rd10_none", 32'h10, 32'hAABBCC55, 2'b00);
        write_same("wr10_mid", 32'h13, 32'h12345678, 4'h6, 2'b00);
        do_read("rd10_mid", 32'h10, 32'hAA345655, 2'b00);

        // Out-of-range accesses
        write_same("wr80", 32'h80, 32'h12345678, 4'hF, 2'b11);
        do_read("rd80", 32'h80, 32'h0, 2'b11);
        do_read("rd00", 32'h00, 32'h0, 2'b00);
        do_read("rdhigh", 32'h1000_0008, 32'h0, 2'b11);

        // Backpressure on both response channels
        S_AWADDR = 32'h14; S_AWVALID = 1'b1;
        S_WDATA = 32'h0BADF00D; S_WSTRB = 4'hF; S_WVALID = 1'b1;
        S_ARADDR = 32'h08; S_ARVALID = 1'b1;
        tick();
        S_AWVALID = 1'b0; S_WVALID = 1'b0; S_ARVALID = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("stall.bvalid", S_BVALID, 1);
            chk("stall.bresp", S_BRESP, 2'b00);
            chk("stall.rvalid", S_RVALID, 1);
            chk("stall.rresp", S_RRESP, 2'b00);
            chk("stall.rdata", S_RDATA, 32'hDEADBEEF);
            chk("stall.awready", S_AWREADY, 0);
            chk("stall.wready", S_WREADY, 0);
            chk("stall.arready", S_ARREADY, 0);
            tick();
        end
        S_BREADY = 1'b1; S_RREADY = 1'b1;
        tick();
        S_BREADY = 1'b0; S_RREADY = 1'b0;
        chk("stall.bvalid_clr", S_BVALID, 0);
        chk("stall.rvalid_clr", S_RVALID, 0);
        do_read("rd14", 32'h14, 32'h0BADF00D, 2'b00);

        // Read and commit to the same index on the same edge
        S_AWADDR = 32'h08; S_AWVALID = 1'b1;
        S_WDATA = 32'h01020304; S_WSTRB = 4'hF; S_WVALID = 1'b1;
        S_ARADDR = 32'h08; S_ARVALID = 1'b1;
        tick();
        S_AWVALID = 1'b0; S_WVALID = 1'b0; S_ARVALID = 1'b0;
        chk("same.rdata_old", S_RDATA, 32'hDEADBEEF);
        chk("same.bvalid", S_BVALID, 1);
        S_BREADY = 1'b1; S_RREADY = 1'b1;
        tick();
        S_BREADY = 1'b0; S_RREADY = 1'b0;
        do_read("same.rd_new", 32'h08, 32'h01020304, 2'b00);

        // Back-to-back reads with RREADY held high
        S_RREADY = 1'b1; S_ARADDR = 32'h08; S_ARVALID = 1'b1;
        tick();
        chk("b2br.rvalid0", S_RVALID, 1);
        chk("b2br.arready0", S_ARREADY, 0);
        chk("b2br.rdata0", S_RDATA, 32'h01020304);
        tick();
        chk("b2br.rvalid1", S_RVALID, 0);
        chk("b2br.arready1", S_ARREADY, 1);
        tick();
        chk("b2br.rvalid2", S_RVALID, 1);
        S_ARVALID = 1'b0;
        tick();
        chk("b2br.rvalid3", S_RVALID, 0);
        S_RREADY = 1'b0;

        // Back-to-back writes with BREADY held high
        S_BREADY = 1'b1;
        S_AWADDR = 32'h20; S_AWVALID = 1'b1;
        S_WDATA = 32'h1; S_WSTRB = 4'hF; S_WVALID = 1'b1;
        tick();
        chk("b2bw.bvalid0", S_BVALID, 1);
        chk("b2bw.awready0", S_AWREADY, 0);
        S_AWADDR = 32'h24; S_WDATA = 32'h2;
        tick();
        chk("b2bw.bvalid1", S_BVALID, 0);
        chk("b2bw.awready1", S_AWREADY, 1);
        tick();
        S_AWVALID = 1'b0; S_WVALID = 1'b0;
        chk("b2bw.bvalid2", S_BVALID, 1);
        tick();
        chk("b2bw.bvalid3", S_BVALID, 0);
        S_BREADY = 1'b0;
        do_read("rd20", 32'h20, 32'h1, 2'b00);
        do_read("rd24", 32'h24, 32'h2, 2'b00);

        // Reset one cycle after a lone AW handshake
        S_AWADDR = 32'h18; S_AWVALID = 1'b1;
        tick();
        S_AWVALID = 1'b0;
        chk("midrst.awready_held", S_AWREADY, 0);
        chk("midrst.wready", S_WREADY, 1);
        tick();
        ARESETN = 1'b0;
        #1;
        chk("midrst.awready", S_AWREADY, 0);
        chk("midrst.wready0", S_WREADY, 0);
        chk("midrst.arready", S_ARREADY, 0);
        chk("midrst.bvalid", S_BVALID, 0);
        chk("midrst.bresp", S_BRESP, 0);
        chk("midrst.rvalid", S_RVALID, 0);
        chk("midrst.rresp", S_RRESP, 0);
        chk("midrst.rdata", S_RDATA, 0);
        tick();
        tick();
        ARESETN = 1'b1;
        #1;
        chk("midrst.awready_after", S_AWREADY, 1);
        chk("midrst.wready_after", S_WREADY, 1);
        chk("midrst.arready_after", S_ARREADY, 1);
        S_WDATA = 32'hCAFEBABE; S_WSTRB = 4'hF; S_WVALID = 1'b1;
        tick();
        S_WVALID = 1'b0;
        chk("midrst.no_commit", S_BVALID, 0);
        chk("midrst.wready_held", S_WREADY, 0);
        S_AWADDR = 32'h1C; S_AWVALID = 1'b1;
        tick();
        S_AWVALID = 1'b0;
        chk("midrst.bvalid_1c", S_BVALID, 1);
        S_BREADY = 1'b1;
        tick();
        S_BREADY = 1'b0;
        do_read("midrst.rd18", 32'h18, 32'h0, 2'b00);
        do_read("midrst.rd1c", 32'h1C, 32'hCAFEBABE, 2'b00);
        do_read("midrst.rd08", 32'h08, 32'h0, 2'b00);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/axi4_lite_regfile.md
AXI4_LITE_REGFILE -- requirements
Module: axi4_lite_regfile

Interface
REQ-001 The block SHALL have parameter ADDRESS, default 32, meaning the AXI address width in bits.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, meaning the data width in bits; legal values are 32 and 64.
REQ-003 The block SHALL have parameter NUM_REGS, default 32, meaning the number of storage registers; legal range is 1..1024.
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-005 ACLK  in  1  clock; all state changes on its rising edge.
REQ-006 ARESETN  in  1  asynchronous active-low reset.
REQ-007 S_AWADDR in ADDRESS; S_AWVALID in 1; S_AWREADY out 1: write address channel.
REQ-008 S_WDATA in DATA_WIDTH; S_WSTRB in DATA_WIDTH/8; S_WVALID in 1; S_WREADY out 1: write data channel.
REQ-009 S_BRESP out 2; S_BVALID out 1; S_BREADY in 1: write response channel.
REQ-010 S_ARADDR in ADDRESS; S_ARVALID in 1; S_ARREADY out 1: read address channel.
REQ-011 S_RDATA out DATA_WIDTH; S_RRESP out 2; S_RVALID out 1; S_RREADY in 1: read data channel.

Function
REQ-012 The register index SHALL be the address bits above log2(DATA_WIDTH/8); the low byte-offset bits are ignored, so there is no unaligned error.
REQ-013 An address with index >= NUM_REGS SHALL decode as out of range and get response DECERR (2'b11); in-range accesses get OKAY (2'b00).
REQ-014 The read path and the write path SHALL be independent and run concurrently, with no arbitration between them.
REQ-015 Write path behaviour:
- AW and W SHALL be accepted in either order or in the same cycle.
- Each channel has a one-entry holding register with a full flag.
- S_AWREADY = !aw_full && !S_BVALID.
- S_WREADY = !w_full && !S_BVALID.
REQ-016 Write commit timing:
- The write SHALL commit on the rising edge where both address and data become available (held or handshaking that cycle).
- S_BVALID SHALL be asserted from the following cycle.
- Both full flags clear on that same edge.
REQ-017 Commit SHALL update only the byte lanes whose S_WSTRB bit is 1; WSTRB=0 commits nothing but still returns OKAY.
REQ-018 An out-of-range write SHALL modify no register and return DECERR.
REQ-019 S_BVALID and S_BRESP SHALL stay stable until S_BREADY is sampled high. At most one write is outstanding.
REQ-020 Read path behaviour:
- S_ARREADY = !S_RVALID.
- On the AR handshake edge, S_RDATA and S_RRESP SHALL be registered and S_RVALID set, giving one cycle of latency.
REQ-021 S_RDATA, S_RRESP and S_RVALID SHALL stay stable until S_RREADY is high. S_RVALID clears on that edge.
REQ-022 When S_RVALID is low, S_RDATA SHALL be 0. An out-of-range read returns data 0 with DECERR.
REQ-023 A read handshake and a write commit to the same index on the same edge SHALL return the pre-write value.
REQ-024 A read issued at least one cycle after a commit SHALL return the new value.
REQ-025 Back-to-back operation:
- With S_RREADY held high, a new AR is accepted in the cycle after S_RVALID clears, so throughput is one read per 2 cycles.
- With S_BREADY held high, writes achieve one per 2 cycles.

Reset
REQ-026 While ARESETN is low, the block SHALL force the following to 0: all outputs, all NUM_REGS registers, aw_full, w_full, S_BVALID and S_RVALID.
REQ-027 Assertion of reset mid-transaction SHALL abandon that transaction with no commit and no response.
REQ-028 After reset deasserts, S_AWREADY, S_WREADY and S_ARREADY SHALL be 1 in the first cycle.

Structure
REQ-029 Package axi4_lite_pkg SHALL hold the response constants (OKAY=2'b00, SLVERR=2'b10, DECERR=2'b11) and a function computing the index width from NUM_REGS.
REQ-030 The block SHALL have no sub-module. Storage, the write FSM (W_IDLE, W_PEND, W_RESP) and the read FSM (R_IDLE, R_DATA) are inline.

Verification
REQ-031 AW at addr 0x08 and W data 0xDEADBEEF/strb 0xF presented in the same cycle -> BVALID next cycle with OKAY; a later read of 0x08 returns 0xDEADBEEF with OKAY.
REQ-032 W (0x11223344, strb 0xF) presented 3 cycles before AW 0x0C -> AWREADY stays high, WREADY drops; commit occurs on the AW edge; BVALID follows.
REQ-033 Reg 4 holds 0xAABBCCDD; write 0x00000055 with strb 0x1 -> read returns 0xAABBCC55.
REQ-034 Write to 0x80 with NUM_REGS=32 -> DECERR, no register changes; read of 0x80 -> RDATA 0 with DECERR.
REQ-035 BREADY and RREADY held low for 5 cycles -> BVALID/RVALID, BRESP/RRESP and RDATA stay stable; AWREADY, WREADY and ARREADY stay low.
REQ-036 Pull ARESETN low one cycle after the AW handshake with W not yet sent -> all outputs are 0, no register is written, and all READY signals are 1 after reset.
